sii_l2t_req_tx: RTL and testbench
=================================

SII_L2T_REQ_TX -- requirements
Module: sii_l2t_req_tx

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 16: number of L2T input-queue entries, which is also the initial IQ credit count.
REQ-002 SHALL have parameter WIB_DEPTH, default 4: number of L2T I/O write-buffer entries, which is also the initial WIB credit count.
REQ-003 SHALL have port iol2clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst_l, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_vld, input, 1 bit: an upstream request is offered.
REQ-006 SHALL have port in_rdy, output, 1 bit: the offered request is accepted this cycle.
REQ-007 SHALL have port in_cmd, input, 2 bits: 0=RD, 1=WR8, 2=WRI, 3=illegal.
REQ-008 SHALL have port in_hdr, input, 64 bits: packet header.
REQ-009 SHALL have port in_data, input, 512 bits: payload; WR8 uses [63:0] only.
REQ-010 SHALL have port sii_l2t_req, output, 32 bits: request bus to the L2T bank.
REQ-011 SHALL have port sii_l2t_req_vld, output, 1 bit: marks the first cycle of a packet.
REQ-012 SHALL have port l2t_sii_iq_dequeue, input, 1 bit: one-cycle pulse that returns one IQ credit.
REQ-013 SHALL have port l2t_sii_wib_dequeue, input, 1 bit: one-cycle pulse that returns one WIB credit.
REQ-014 SHALL have port iq_cred, output, 5 bits: current IQ credit count.
REQ-015 SHALL have port wib_cred, output, 3 bits: current WIB credit count.
REQ-016 SHALL have port err, output, 1 bit: sticky error flag (illegal command or credit overflow).

Function
REQ-017 in_rdy SHALL be combinational and high only when all hold: state=IDLE; iq_cred!=0; in_cmd!=3; and, if in_cmd=WRI, wib_cred!=0.
REQ-018 A request SHALL be accepted when in_vld and in_rdy are both high; on acceptance, cmd, hdr and data are registered.
REQ-019 The FSM SHALL have states IDLE, HDR0, HDR1, DATA and GAP; acceptance moves IDLE to HDR0 on the next edge.
REQ-020 Latency: sii_l2t_req_vld SHALL be high for exactly one cycle, the cycle after acceptance (HDR0).
REQ-021 In HDR0, sii_l2t_req SHALL carry hdr[63:32]; in HDR1 it SHALL carry hdr[31:0].
REQ-022 From HDR1 the FSM SHALL go to DATA if cmd is WR8 or WRI, and to GAP if cmd is RD.
REQ-023 DATA SHALL send 32-bit beats MSW first: WR8 sends 2 beats (data[63:32], then data[31:0]); WRI sends 16 beats (data[511:480] down to data[31:0]).
REQ-024 A 4-bit beat counter SHALL clear on entry to DATA; the FSM SHALL move to GAP after the last beat.
REQ-025 GAP SHALL last exactly one cycle (dummy cycle with sii_l2t_req=0) and then return to IDLE; the minimum packet spacing is therefore 4 (RD), 6 (WR8) or 20 (WRI) cycles.
REQ-026 sii_l2t_req SHALL be 0 in IDLE and in GAP.
REQ-027 Each acceptance SHALL decrement iq_cred by 1; a WRI acceptance SHALL additionally decrement wib_cred by 1.
REQ-028 Each dequeue pulse SHALL increment the corresponding counter by 1.
REQ-029 If an acceptance and a dequeue for the same counter occur in the same cycle, that counter SHALL stay unchanged.
REQ-030 A dequeue arriving while its counter is already at DEPTH (with no simultaneous decrement) SHALL saturate the counter and set err.
REQ-031 err SHALL also be set when in_vld is high with in_cmd=3; that request is never accepted.
REQ-032 err SHALL clear only on reset.
REQ-033 Dequeue pulses SHALL be honoured in every FSM state.

Reset
REQ-034 While rst_l is low, asynchronously: state=IDLE; sii_l2t_req=0; sii_l2t_req_vld=0; beat counter=0; err=0; iq_cred=IQ_DEPTH; wib_cred=WIB_DEPTH.
REQ-035 A reset asserted mid-packet SHALL abandon the packet and restore full credits; no partial beats SHALL be driven after rst_l deasserts.
REQ-036 After rst_l deasserts, in_rdy SHALL be able to go high on the first clock.

Structure
REQ-037 Package sii_l2t_pkg SHALL hold: the command encodings, the FSM state enum, beat counts (WR8=2, WRI=16), and the default depths.
REQ-038 Sub-module sii_l2t_cred_cnt (parameter DEPTH; inc/dec inputs; count and overflow outputs) SHALL be instantiated twice, once for IQ and once for WIB.

Verification
REQ-039 RD with hdr=64'hA5A5_0000_1234_5678 accepted at cycle N SHALL give: vld=1 and req=A5A50000 at N+1; req=12345678 at N+2; req=0 at N+3; in_rdy able to go high again at N+4; iq_cred 16 to 15.
REQ-040 A WRI with data beats 0..15 SHALL send 16 beats in MSW order from N+3 to N+18 with GAP at N+19; iq_cred SHALL drop by 1 and wib_cred from 4 to 3.
REQ-041 Five back-to-back WRIs with no dequeue SHALL be accepted four times; the fifth SHALL hold in_rdy=0 until a wib_dequeue pulse, then be accepted in the next cycle that is in IDLE.
REQ-042 An iq_dequeue in the same cycle as an acceptance SHALL leave iq_cred unchanged; an iq_dequeue while iq_cred=16 SHALL leave iq_cred at 16 and set err=1.
REQ-043 With in_cmd=3 and in_vld=1, in_rdy SHALL stay 0 and err SHALL be 1 on the next edge.
REQ-044 Asserting rst_l low during WRI beat 7 SHALL immediately give vld=0, req=0, iq_cred=16, wib_cred=4, with no further beats after release.

Source files
------------

// File: rtl/sii_l2t_pkg.sv
// Shared encodings and constants for the SII-to-L2T request transmitter.
package sii_l2t_pkg;

  typedef enum logic [1:0] {
    CmdRd  = 2'd0,
    CmdWr8 = 2'd1,
    CmdWri = 2'd2,
    CmdIll = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StGap
  } state_e;

  localparam int unsigned BeatsWr8    = 2;
  localparam int unsigned BeatsWri    = 16;
  localparam int unsigned IqDepthDef  = 16;
  localparam int unsigned WibDepthDef = 4;

  // Index of the final data beat for a write command.
  function automatic logic [3:0] last_beat(cmd_e cmd);
    return (cmd == CmdWri) ? 4'(BeatsWri - 1) : 4'(BeatsWr8 - 1);
  endfunction

endpackage

// File: rtl/sii_l2t_cred_cnt.sv
// Saturating credit counter: dec consumes a credit, inc returns one.
// Returning a credit into a full counter flags overflow and is dropped.
module sii_l2t_cred_cnt #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             iol2clk,
  input  logic             rst_l,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] Full = WIDTH'(DEPTH);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count; simultaneous inc and dec cancel out.
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (inc && !dec) begin
      if (count_q == Full) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec && !inc) begin
      count_d = count_q - 1'b1;
    end
  end

  // Credit register, full on reset.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      count_q <= Full;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sii_l2t_req_tx.sv
// Serialises accepted requests onto the 32-bit L2T request bus:
// two header words, optional data beats (MSW first), then one idle gap cycle.
module sii_l2t_req_tx
  import sii_l2t_pkg::*;
#(
  parameter int unsigned IQ_DEPTH  = IqDepthDef,
  parameter int unsigned WIB_DEPTH = WibDepthDef
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [1:0]   in_cmd,
  input  logic [63:0]  in_hdr,
  input  logic [511:0] in_data,
  output logic [31:0]  sii_l2t_req,
  output logic         sii_l2t_req_vld,
  input  logic         l2t_sii_iq_dequeue,
  input  logic         l2t_sii_wib_dequeue,
  output logic [4:0]   iq_cred,
  output logic [2:0]   wib_cred,
  output logic         err
);

  state_e         state_q, state_d;
  logic   [3:0]   beat_q, beat_d;
  logic   [3:0]   word;
  cmd_e           cmd_q;
  logic   [63:0]  hdr_q;
  logic   [511:0] data_q;
  logic           err_q;
  logic           accept;
  logic           wib_take;
  logic           iq_ovf, wib_ovf;

  // Ready only when idle with the credits this command needs.
  always_comb begin
    in_rdy = (state_q == StIdle) && (iq_cred != '0) && (in_cmd != CmdIll) &&
             ((in_cmd != CmdWri) || (wib_cred != '0));
  end

  assign accept   = in_vld && in_rdy;
  assign wib_take = accept && (in_cmd == CmdWri);
  assign word     = last_beat(cmd_q) - beat_q;

  sii_l2t_cred_cnt #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (5)
  ) u_iq_cred (
    .iol2clk  (iol2clk),
    .rst_l    (rst_l),
    .inc      (l2t_sii_iq_dequeue),
    .dec      (accept),
    .count    (iq_cred),
    .overflow (iq_ovf)
  );

  sii_l2t_cred_cnt #(
    .DEPTH (WIB_DEPTH),
    .WIDTH (3)
  ) u_wib_cred (
    .iol2clk  (iol2clk),
    .rst_l    (rst_l),
    .inc      (l2t_sii_wib_dequeue),
    .dec      (wib_take),
    .count    (wib_cred),
    .overflow (wib_ovf)
  );

  // Next-state and bus outputs; the bus is decoded straight from state.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    sii_l2t_req     = '0;
    sii_l2t_req_vld = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StHdr0;
      end
      StHdr0: begin
        sii_l2t_req_vld = 1'b1;
        sii_l2t_req     = hdr_q[63:32];
        state_d         = StHdr1;
      end
      StHdr1: begin
        sii_l2t_req = hdr_q[31:0];
        beat_d      = '0;
        state_d     = (cmd_q == CmdRd) ? StGap : StData;
      end
      StData: begin
        sii_l2t_req = data_q[{word, 5'b0} +: 32];
        if (beat_q == last_beat(cmd_q)) begin
          state_d = StGap;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, beat counter and captured request.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      beat_q  <= '0;
      cmd_q   <= CmdRd;
      hdr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (accept) begin
        cmd_q  <= cmd_e'(in_cmd);
        hdr_q  <= in_hdr;
        data_q <= in_data;
      end
    end
  end

  // Sticky error: illegal command offered or a credit returned into a full counter.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | iq_ovf | wib_ovf | (in_vld && (in_cmd == CmdIll));
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_sii_l2t_req_tx.sv
// Directed bench for sii_l2t_req_tx with a packet-stream reference model.
module tb_sii_l2t_req_tx;

  localparam int IqDepth  = 16;
  localparam int WibDepth = 4;

  logic         iol2clk = 1'b0;
  logic         rst_l   = 1'b1;
  logic         in_vld  = 1'b0;
  logic         in_rdy;
  logic [1:0]   in_cmd  = 2'd0;
  logic [63:0]  in_hdr  = '0;
  logic [511:0] in_data = '0;
  logic [31:0]  sii_l2t_req;
  logic         sii_l2t_req_vld;
  logic         l2t_sii_iq_dequeue  = 1'b0;
  logic         l2t_sii_wib_dequeue = 1'b0;
  logic [4:0]   iq_cred;
  logic [2:0]   wib_cred;
  logic         err;

  int errors = 0;
  int checks = 0;

  sii_l2t_req_tx #(
    .IQ_DEPTH  (IqDepth),
    .WIB_DEPTH (WibDepth)
  ) dut (
    .iol2clk             (iol2clk),
    .rst_l               (rst_l),
    .in_vld              (in_vld),
    .in_rdy              (in_rdy),
    .in_cmd              (in_cmd),
    .in_hdr              (in_hdr),
    .in_data             (in_data),
    .sii_l2t_req         (sii_l2t_req),
    .sii_l2t_req_vld     (sii_l2t_req_vld),
    .l2t_sii_iq_dequeue  (l2t_sii_iq_dequeue),
    .l2t_sii_wib_dequeue (l2t_sii_wib_dequeue),
    .iq_cred             (iq_cred),
    .wib_cred            (wib_cred),
    .err                 (err)
  );

  always #5 iol2clk = ~iol2clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: expected bus words per cycle, credit counts, sticky error.
  typedef struct packed {
    logic        vld;
    logic [31:0] w;
  } beat_t;

  beat_t mq[$];
  int    m_iq  = IqDepth;
  int    m_wib = WibDepth;
  logic  m_err = 1'b0;

  always @(negedge iol2clk) begin
    logic        exp_vld;
    logic [31:0] exp_req;
    logic        exp_rdy;
    logic        acc;
    int          nb;
    if (!rst_l) begin
      check("rst_vld", 64'(sii_l2t_req_vld), 64'd0);
      check("rst_req", 64'(sii_l2t_req), 64'd0);
      check("rst_iq", 64'(iq_cred), 64'(IqDepth));
      check("rst_wib", 64'(wib_cred), 64'(WibDepth));
      check("rst_err", 64'(err), 64'd0);
      mq.delete();
      m_iq  = IqDepth;
      m_wib = WibDepth;
      m_err = 1'b0;
    end else begin
      exp_vld = (mq.size() != 0) ? mq[0].vld : 1'b0;
      exp_req = (mq.size() != 0) ? mq[0].w : 32'd0;
      exp_rdy = (mq.size() == 0) && (m_iq > 0) && (in_cmd != 2'd3) &&
                ((in_cmd != 2'd2) || (m_wib > 0));
      check("m_vld", 64'(sii_l2t_req_vld), 64'(exp_vld));
      check("m_req", 64'(sii_l2t_req), 64'(exp_req));
      check("m_rdy", 64'(in_rdy), 64'(exp_rdy));
      check("m_iq", 64'(iq_cred), 64'(m_iq));
      check("m_wib", 64'(wib_cred), 64'(m_wib));
      check("m_err", 64'(err), 64'(m_err));
      acc = in_vld && exp_rdy;
      if (mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({1'b1, in_hdr[63:32]});
        mq.push_back({1'b0, in_hdr[31:0]});
        nb = (in_cmd == 2'd1) ? 2 : (in_cmd == 2'd2) ? 16 : 0;
        for (int i = nb - 1; i >= 0; i--) mq.push_back({1'b0, in_data[32*i +: 32]});
        mq.push_back({1'b0, 32'd0});
      end
      if (acc && !l2t_sii_iq_dequeue) m_iq--;
      else if (l2t_sii_iq_dequeue && !acc) begin
        if (m_iq == IqDepth) m_err = 1'b1;
        else m_iq++;
      end
      if (acc && (in_cmd == 2'd2) && !l2t_sii_wib_dequeue) m_wib--;
      else if (l2t_sii_wib_dequeue && !(acc && (in_cmd == 2'd2))) begin
        if (m_wib == WibDepth) m_err = 1'b1;
        else m_wib++;
      end
      if (in_vld && (in_cmd == 2'd3)) m_err = 1'b1;
    end
  end

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic do_reset();
    in_vld              = 1'b0;
    l2t_sii_iq_dequeue  = 1'b0;
    l2t_sii_wib_dequeue = 1'b0;
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  // Offer a request until accepted; returns one cycle after acceptance.
  task automatic send(input logic [1:0] cmd, input logic [63:0] hdr, input logic [511:0] data);
    bit done = 0;
    in_cmd  = cmd;
    in_hdr  = hdr;
    in_data = data;
    in_vld  = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge iol2clk);
      if (in_rdy) done = 1;
    end
    if (done) begin
      tick();
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance, expected in_rdy within 100 cycles");
    end
    in_vld = 1'b0;
  endtask

  task automatic pulse_iq();
    l2t_sii_iq_dequeue = 1'b1;
    tick();
    l2t_sii_iq_dequeue = 1'b0;
  endtask

  logic [511:0] wri_data;
  int           bad;

  initial begin
    for (int i = 0; i < 16; i++) wri_data[32*i +: 32] = 32'(15 - i);

    #1 rst_l = 1'b0;
    tick();
    tick();
    check("reset_iq", 64'(iq_cred), 64'd16);
    check("reset_wib", 64'(wib_cred), 64'd4);
    check("reset_err", 64'(err), 64'd0);
    rst_l  = 1'b1;
    in_cmd = 2'd0;
    #1 check("rdy_after_reset", 64'(in_rdy), 64'd1);

    // RD packet
    send(2'd0, 64'hA5A5_0000_1234_5678, '0);
    check("rd_vld", 64'(sii_l2t_req_vld), 64'd1);
    check("rd_hdr_hi", 64'(sii_l2t_req), 64'hA5A50000);
    check("rd_iq", 64'(iq_cred), 64'd15);
    tick();
    check("rd_hdr_lo", 64'(sii_l2t_req), 64'h12345678);
    check("rd_vld_once", 64'(sii_l2t_req_vld), 64'd0);
    tick();
    check("rd_gap", 64'(sii_l2t_req), 64'd0);
    tick();
    check("rd_rdy_again", 64'(in_rdy), 64'd1);
    pulse_iq();

    // WR8 packet: only data[63:0] goes out
    send(2'd1, 64'h1111_2222_3333_4444, {{14{32'hFFFF_FFFF}}, 64'hDEAD_BEEF_CAFE_F00D});
    tick();
    tick();
    check("wr8_beat0", 64'(sii_l2t_req), 64'hDEADBEEF);
    tick();
    check("wr8_beat1", 64'(sii_l2t_req), 64'hCAFEF00D);
    tick();
    check("wr8_gap", 64'(sii_l2t_req), 64'd0);
    pulse_iq();

    // WRI packet: beat k carries k
    send(2'd2, 64'h0BAD_F00D_0000_0001, wri_data);
    check("wri_wib", 64'(wib_cred), 64'd3);
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      check("wri_beat", 64'(sii_l2t_req), 64'(k));
    end
    tick();
    check("wri_gap", 64'(sii_l2t_req), 64'd0);

    // Five WRIs, only four WIB credits
    do_reset();
    for (int j = 0; j < 4; j++) send(2'd2, 64'(j), wri_data);
    in_cmd = 2'd2;
    in_vld = 1'b1;
    repeat (25) tick();
    check("wri5_blocked", 64'(in_rdy), 64'd0);
    check("wri5_wib0", 64'(wib_cred), 64'd0);
    l2t_sii_wib_dequeue = 1'b1;
    tick();
    l2t_sii_wib_dequeue = 1'b0;
    check("wri5_wib1", 64'(wib_cred), 64'd1);
    check("wri5_rdy", 64'(in_rdy), 64'd1);
    send(2'd2, 64'd4, wri_data);
    check("wri5_wib_after", 64'(wib_cred), 64'd0);
    check("wri5_iq_after", 64'(iq_cred), 64'd11);
    repeat (20) tick();

    // Same-cycle accept and dequeue, then overflow
    do_reset();
    in_cmd = 2'd0;
    in_vld = 1'b1;
    l2t_sii_iq_dequeue = 1'b1;
    tick();
    in_vld = 1'b0;
    l2t_sii_iq_dequeue = 1'b0;
    check("iq_simul", 64'(iq_cred), 64'd16);
    check("iq_simul_err", 64'(err), 64'd0);
    repeat (4) tick();
    pulse_iq();
    check("iq_ovf_cnt", 64'(iq_cred), 64'd16);
    check("iq_ovf_err", 64'(err), 64'd1);

    // Illegal command
    do_reset();
    in_cmd = 2'd3;
    in_vld = 1'b1;
    @(negedge iol2clk);
    check("ill_rdy", 64'(in_rdy), 64'd0);
    tick();
    in_vld = 1'b0;
    check("ill_err", 64'(err), 64'd1);

    // Reset during WRI beat 7
    do_reset();
    send(2'd2, 64'hFEED_0000_0000_0007, wri_data);
    repeat (9) tick();
    check("mid_beat7", 64'(sii_l2t_req), 64'd7);
    rst_l = 1'b0;
    #1;
    check("mid_rst_vld", 64'(sii_l2t_req_vld), 64'd0);
    check("mid_rst_req", 64'(sii_l2t_req), 64'd0);
    check("mid_rst_iq", 64'(iq_cred), 64'd16);
    check("mid_rst_wib", 64'(wib_cred), 64'd4);
    tick();
    tick();
    rst_l = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge iol2clk);
      if (sii_l2t_req != 32'd0 || sii_l2t_req_vld) bad++;
    end
    check("mid_no_beats", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
